// File: rtl/ibex_sec_erase_seq.sv
// ibex_sec_erase_seq: secure-erase sequencer for the flop register file.
// Takes an erase mask and strobes sec_ers_o at most EraseWidth registers per
// cycle, lowest index first. A same-cycle writeback to a pending register
// wins: that register is dropped from the erase and never strobed.
// Optional feature macro: SEC_ERASE_STALL_EN (drives stall_o while erasing).
module ibex_sec_erase_seq #(
  parameter int NumRegs    = 32,
  parameter int EraseWidth = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_mask_i,
  input  logic        flush_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_waddr_i,
  output logic [31:0] sec_ers_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {IDLE, ERASE, DONE} state_e;

  // x0 is hardwired and registers past NumRegs do not exist.
  function automatic logic [31:0] valid_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 1; i < 32; i++) m[i] = (i < NumRegs);
    return m;
  endfunction

  localparam logic [31:0] ValidMask = valid_mask();

  state_e      state_q;
  logic [31:0] pending_q;
  logic        ready_q, busy_q, done_q;
  logic [31:0] wb_bit, cand, ers, pending_nxt;

  // One-hot of the register being written this cycle (x0 writes are ignored).
  always_comb begin
    wb_bit = '0;
    if (wb_we_i && (wb_waddr_i != 5'd0)) wb_bit[wb_waddr_i] = 1'b1;
  end

  assign cand = pending_q & ~wb_bit & ValidMask;

  // Pick the lowest-indexed EraseWidth candidates for this cycle.
  always_comb begin
    int cnt;
    cnt = 0;
    ers = '0;
    for (int i = 0; i < 32; i++) begin
      if (cand[i] && (cnt < EraseWidth)) begin
        ers[i] = 1'b1;
        cnt    = cnt + 1;
      end
    end
  end

  assign pending_nxt = pending_q & ~ers & ~wb_bit;
  assign sec_ers_o   = ((state_q == ERASE) && !flush_i) ? ers : '0;

  // Sequencer FSM with registered status outputs; flush overrides everything.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (flush_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            pending_q <= req_mask_i & ValidMask;
            ready_q   <= 1'b0;
            if ((req_mask_i & ValidMask) != '0) begin
              state_q <= ERASE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ERASE: begin
          pending_q <= pending_nxt;
          if (pending_nxt == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= '0;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef SEC_ERASE_STALL_EN
  assign stall_o = busy_q | (req_valid_i & ready_q);
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: doc/ibex_sec_erase_seq.md
# ibex_sec_erase_seq

Secure-erase sequencer driving the per-register erase strobe bus (`sec_ers`) of the index-remapped flop register file. Accepts an erase mask from the ID/EX stage, rate-limits erases to a fixed number of architectural registers per cycle, and arbitrates against same-cycle writeback so fresh write data is never destroyed. Signals completion and optionally stalls the core while an erase is in progress.

## Interface
- `NumRegs`, 32: architectural registers (16 for RV32E); mask bits at and above `NumRegs` are ignored.
- `EraseWidth`, 4: maximum erase strobes asserted per cycle (1..NumRegs).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  erase request valid.
- `req_ready_o`  out  1  sequencer can accept a request.
- `req_mask_i`  in  32  architectural registers to erase; bit r is x_r.
- `flush_i`  in  1  abandon the pending erase (pipeline flush).
- `wb_we_i`  in  1  register file write enable this cycle.
- `wb_waddr_i`  in  5  register file write address this cycle.
- `sec_ers_o`  out  32  per-register erase strobes to the register file.
- `busy_o`  out  1  erase pending.
- `done_o`  out  1  single-cycle completion pulse.
- `stall_o`  out  1  core stall request.

## Operation
- State: `IDLE`, `ERASE`, `DONE`. Register: `pending_q[31:0]`.
- Reset values: state=`IDLE`, pending_q=0, req_ready_o=1, sec_ers_o=0, busy_o=0, done_o=0, stall_o=0.
- `IDLE`: req_ready_o=1. On req_valid_i: pending_q <= req_mask_i with bit 0 and bits ≥NumRegs cleared; next state `ERASE` if the result is nonzero, else `DONE`.
- `ERASE`: req_ready_o=0, busy_o=1.
  - cand = pending_q with bit wb_waddr_i cleared when wb_we_i=1 and wb_waddr_i≠0.
  - sec_ers_o = the lowest-indexed (up to) EraseWidth set bits of cand. Combinational from pending_q and the wb inputs.
  - pending_q <= pending_q & ~sec_ers_o & ~(write bit). A same-cycle write supersedes the erase: that bit is dropped and never strobed.
  - When the next pending_q is 0, go to `DONE`.
- `DONE`: done_o=1, busy_o=0, req_ready_o=0, sec_ers_o=0. Next state `IDLE`.
- flush_i (any state): pending_q <= 0, state <= `IDLE`, and sec_ers_o is forced to 0 that cycle. No done_o pulse. Takes priority over a same-cycle req_valid_i, which is not accepted.
- sec_ers_o bit 0 is never asserted; bits ≥NumRegs are never asserted.
- Asserting rst_ni mid-erase returns all state to reset values. Unerased bits are lost and no done_o pulse is produced.

## Timing
- Request accepted at edge T. First strobes are visible during cycle T+1.
- With no write conflicts, ERASE lasts ceil(popcount/EraseWidth) cycles. done_o is high in the following cycle, and req_ready_o returns the cycle after that.
- An empty effective mask gives done_o in cycle T+1 and no strobes.
- Minimum request-to-request spacing: 2 cycles for an empty mask, otherwise (ERASE cycles + 2).
- Each strobe lasts exactly one cycle. The register file clears on the following edge.

## Configuration
- `SEC_ERASE_STALL_EN` defined: stall_o = busy_o | (req_valid_i & req_ready_o). The core holds from the accept cycle until the cycle done_o is high (inclusive of accept, exclusive of DONE).
- Not defined: stall_o tied to 0. The core proceeds and relies on done_o; the write-supersedes rule keeps results correct.

## Test plan
- Reset, then mask 0x0000_00F0 with EraseWidth=4: sec_ers_o=0x0000_00F0 at T+1, done_o at T+2, req_ready_o=1 at T+3.
- Mask 0xFFFF_FFFF with EraseWidth=4:
  - Strobes 0x1E, 0x1E0, … in 8 cycles (the last covers bits 29–31 only).
  - Bit 0 never strobed.
  - done_o follows the final strobe cycle.
- Mask 0x0000_000F, wb_we_i=1, wb_waddr_i=2 in cycle T+1: sec_ers_o=0x0000_000A, pending_q → 0, done_o at T+2. x2 retains the written value.
- Mask 0x0000_0001 or 0: no strobes, done_o at T+1.
- Mask 0x0000_FF00, flush_i in the second ERASE cycle: sec_ers_o=0 that cycle, busy_o=0 next cycle, done_o never asserted. A new request is accepted the cycle after the flush.
- rst_ni low mid-ERASE: all outputs return to reset values asynchronously and no strobes follow. With `SEC_ERASE_STALL_EN`, stall_o is high for exactly the accept and ERASE cycles.
